// File: rtl/jpeg_strip_block_reader.sv
// Strip line-buffer read controller: walks 8 lines in 8x8-block order and
// streams one 64-bit block row per beat through a small tagged output FIFO.
module jpeg_strip_block_reader #(
  parameter int MAX_HWORDS = 180,
  parameter int FIFO_DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  hwords_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        rd_en_o,
  output logic [10:0] rd_addr_o,
  input  logic [63:0] rd_data_i,
  output logic [63:0] data_o,
  output logic [2:0]  row_o,
  output logic [7:0]  blk_o,
  output logic        last_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PLAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [7:0] MAXH = 8'(MAX_HWORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  h_q, h_d;
  logic [7:0]  blk_q, blk_d;
  logic [2:0]  row_q, row_d;
  logic [10:0] base_q, base_d;
  logic        infl_q;
  logic [2:0]  trow_q;
  logic [7:0]  tblk_q;
  logic        tlast_q;

  logic [63:0] fdata_q [FIFO_DEPTH];
  logic [2:0]  frow_q  [FIFO_DEPTH];
  logic [7:0]  fblk_q  [FIFO_DEPTH];
  logic        flast_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [7:0]    hclamp;
  logic [CW-1:0] occ;
  logic          issue, is_last, valid, pop, push;

  assign hclamp  = (hwords_i > MAXH) ? MAXH : hwords_i;
  assign occ     = count_q + CW'(infl_q);
  assign issue   = (state_q == S_READ) && (occ < DEPTH);
  assign is_last = (row_q == 3'd7) && (blk_q == h_q - 8'd1);
  assign valid   = (count_q != '0);
  assign pop     = valid & ready_i;
  assign push    = infl_q;

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign rd_en_o   = issue;
  assign rd_addr_o = base_q + {3'b000, blk_q};
  assign valid_o   = valid;
  assign data_o    = valid ? fdata_q[rptr_q] : '0;
  assign row_o     = valid ? frow_q[rptr_q] : '0;
  assign blk_o     = valid ? fblk_q[rptr_q] : '0;
  assign last_o    = valid ? flast_q[rptr_q] : 1'b0;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    blk_d   = blk_q;
    row_d   = row_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          h_d     = hclamp;
          blk_d   = '0;
          row_d   = '0;
          base_d  = '0;
          state_d = (hclamp == 8'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          if (row_q == 3'd7) begin
            row_d  = '0;
            base_d = '0;
            blk_d  = blk_q + 8'd1;
          end else begin
            row_d  = row_q + 3'd1;
            base_d = base_q + {3'b000, h_q};
          end
          if (is_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the last beat pops so done lands one cycle after it.
        if (!infl_q &&
            ((count_q == '0) || ((count_q == CW'(1)) && pop)))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      blk_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      infl_q  <= 1'b0;
      trow_q  <= '0;
      tblk_q  <= '0;
      tlast_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      blk_q   <= blk_d;
      row_q   <= row_d;
      base_q  <= base_d;
      infl_q  <= issue;
      if (issue) begin
        trow_q  <= row_q;
        tblk_q  <= blk_q;
        tlast_q <= is_last;
      end
      if (push) wptr_q <= inc(wptr_q);
      if (pop)  rptr_q <= inc(rptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fdata_q[wptr_q] <= rd_data_i;
      frow_q[wptr_q]  <= trow_q;
      fblk_q[wptr_q]  <= tblk_q;
      flast_q[wptr_q] <= tlast_q;
    end
  end

endmodule

// File: tb/tb_jpeg_strip_block_reader.sv
// Directed bench for jpeg_strip_block_reader with a 1-cycle buffer model.
module tb_jpeg_strip_block_reader;

  localparam logic [63:0] PAT = 64'hC0DE_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_i, start_i, ready_i;
  logic [7:0]  hwords_i;
  logic        busy_o, done_o, rd_en_o, last_o, valid_o;
  logic [10:0] rd_addr_o;
  logic [63:0] rd_data_i, data_o;
  logic [2:0]  row_o;
  logic [7:0]  blk_o;
  logic [63:0] mem [1440];

  int total = 0;
  int bad = 0;

  jpeg_strip_block_reader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .hwords_i(hwords_i), .busy_o(busy_o), .done_o(done_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .data_o(data_o), .row_o(row_o),
    .blk_o(blk_o), .last_o(last_o), .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_strip(input logic [7:0] hw, input int exph,
                           input int pct, input int inj);
    int nb, k, j, cyc, budget, ea;
    bit seen, lastho, dseen, stl;
    logic [63:0] hd;
    logic [2:0]  hr;
    logic [7:0]  hb;
    logic        hl;
    nb = 8 * exph;
    k = 0; j = 0; cyc = 0;
    budget = nb * 10 + 50;
    seen = 0; dseen = 0; stl = 0;
    lastho = (exph == 0);
    start_i = 1'b1;
    hwords_i = hw;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_rise", 64'(busy_o), 64'd1);
    while (!dseen && cyc < budget) begin
      start_i = (cyc == inj);
      if (cyc == inj) hwords_i = 8'd5;
      ready_i = ($urandom_range(99) < pct);
      if (rd_en_o) begin
        ea = (j % 8) * exph + j / 8;
        check("rd_addr", 64'(rd_addr_o), 64'(ea));
        check("occ_lt3", 64'(j - k < 3), 64'd1);
        j++;
      end
      check("done", 64'(done_o), 64'(lastho));
      if (done_o) dseen = 1;
      lastho = 0;
      if (stl) begin
        check("hold_valid", 64'(valid_o), 64'd1);
        check("hold_data", data_o, hd);
        check("hold_tag", {hr, hb, hl}, {hr, hb, hl} == {row_o, blk_o, last_o} ?
              {row_o, blk_o, last_o} : ~{hr, hb, hl});
      end
      if (valid_o && !seen) begin
        seen = 1;
        if (pct == 100) check("first_lat", 64'(cyc), 64'd2);
      end
      if (pct == 100 && seen && k < nb)
        check("no_bubble", 64'(valid_o), 64'd1);
      if (valid_o && ready_i) begin
        ea = (k % 8) * exph + k / 8;
        check("data", data_o, PAT | 64'(ea));
        check("row", 64'(row_o), 64'(k % 8));
        check("blk", 64'(blk_o), 64'(k / 8));
        check("last", 64'(last_o), 64'(k == nb - 1));
        k++;
        lastho = (k == nb);
      end
      stl = valid_o && !ready_i;
      hd = data_o; hr = row_o; hb = blk_o; hl = last_o;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    if (!dseen) check("timeout", 64'd0, 64'd1);
    check("beats", 64'(k), 64'(nb));
    check("reads", 64'(j), 64'(nb));
    check("busy_fall", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int k, c;
    for (int i = 0; i < 1440; i++) mem[i] = PAT | 64'(i);
    rst_i = 1'b1; start_i = 1'b0; hwords_i = '0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rden", 64'(rd_en_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_addr", 64'(rd_addr_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_row", 64'(row_o), 64'd0);
    check("rst_blk", 64'(blk_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    run_strip(8'd2, 2, 100, -1);
    run_strip(8'd180, 180, 100, -1);
    run_strip(8'd4, 4, 30, -1);
    run_strip(8'd0, 0, 100, -1);
    run_strip(8'd200, 180, 100, -1);
    run_strip(8'd3, 3, 100, 5);

    // Abandon a strip with a full FIFO and a stalled sink.
    k = 0; c = 0;
    ready_i = 1'b1; start_i = 1'b1; hwords_i = 8'd4;
    @(negedge clk);
    start_i = 1'b0;
    while (k < 5 && c < 50) begin
      if (valid_o && ready_i) k++;
      if (k < 5) begin
        @(negedge clk);
        c++;
      end
    end
    @(negedge clk);
    ready_i = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_k", 64'(k), 64'd5);
    check("pre_rst_valid", 64'(valid_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", 64'(done_o), 64'd0);
      check("post_rst_valid", 64'(valid_o), 64'd0);
    end
    run_strip(8'd1, 1, 100, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
